// File: rtl/iter_compare_unit_if.sv
// Control-unit handshake and operand/result bundle for iter_compare_unit.
// The control unit uses the master view; the comparator uses the slave view.
interface iter_compare_unit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       mode;
  logic             sgn;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             eq;
  logic             lt;
  logic             gt;

  modport master (
    output start, a, b, mode, sgn,
    input  busy, done, y, eq, lt, gt
  );

  modport slave (
    input  start, a, b, mode, sgn,
    output busy, done, y, eq, lt, gt
  );
endinterface

// File: rtl/iter_compare_unit.sv
// Multi-cycle MSB-first digit-serial comparator with early exit.
// Produces CMP/MAX/MIN result words and registered eq/lt/gt flags.
module iter_compare_unit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  iter_compare_unit_if.slave bus
);
  localparam int DIG_SAFE = (DIGIT < 1) ? 1 : DIGIT;
  localparam int NDIG     = WIDTH / DIG_SAFE;
  localparam int KW       = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if ((DIGIT < 1) || (WIDTH % DIG_SAFE != 0)) begin : g_bad_digit
      $error("iter_compare_unit: DIGIT must be positive and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] a_cmp_reg, b_cmp_reg;
  logic [1:0]       mode_reg;
  logic [KW-1:0]    k_reg;
  logic [WIDTH-1:0] y_reg, y_next;
  logic             eq_reg, lt_reg, gt_reg;

  logic [DIG_SAFE-1:0] a_dig [NDIG];
  logic [DIG_SAFE-1:0] b_dig [NDIG];
  logic                dig_gt, dig_lt, last_dig, accept, finish;

  // Digit 0 is the most significant slice of the (possibly MSB-flipped) copies.
  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digits
      assign a_dig[gi] = a_cmp_reg[WIDTH-1-gi*DIG_SAFE -: DIG_SAFE];
      assign b_dig[gi] = b_cmp_reg[WIDTH-1-gi*DIG_SAFE -: DIG_SAFE];
    end
  endgenerate

  assign dig_gt   = a_dig[k_reg] > b_dig[k_reg];
  assign dig_lt   = a_dig[k_reg] < b_dig[k_reg];
  assign last_dig = (k_reg == KW'(NDIG - 1));
  assign accept   = bus.start && ((state_reg == IDLE) || (state_reg == DONE));
  assign finish   = (state_reg == BUSY) && (dig_gt || dig_lt || last_dig);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = BUSY;
      BUSY:    if (dig_gt || dig_lt || last_dig) state_next = DONE;
      DONE:    state_next = bus.start ? BUSY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Ties select operand a for both MAX and MIN.
  always_comb begin
    y_next = '0;
    case (mode_reg)
      2'b01:   y_next = dig_lt ? b_reg : a_reg;
      2'b10:   y_next = dig_gt ? b_reg : a_reg;
      default: y_next = WIDTH'(dig_gt);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      a_cmp_reg <= '0;
      b_cmp_reg <= '0;
      mode_reg  <= '0;
      k_reg     <= '0;
      y_reg     <= '0;
      eq_reg    <= 1'b0;
      lt_reg    <= 1'b0;
      gt_reg    <= 1'b0;
    end else begin
      if (accept) begin
        a_reg     <= bus.a;
        b_reg     <= bus.b;
        // Flipping the sign bit maps two's-complement order onto unsigned order.
        a_cmp_reg <= bus.a ^ {bus.sgn, {(WIDTH-1){1'b0}}};
        b_cmp_reg <= bus.b ^ {bus.sgn, {(WIDTH-1){1'b0}}};
        mode_reg  <= bus.mode;
        k_reg     <= '0;
      end else if ((state_reg == BUSY) && !finish) begin
        k_reg <= k_reg + KW'(1);
      end
      if (finish) begin
        y_reg  <= y_next;
        eq_reg <= !dig_gt && !dig_lt;
        lt_reg <= dig_lt;
        gt_reg <= dig_gt;
      end
    end
  end

  assign bus.busy = (state_reg == BUSY);
  assign bus.done = (state_reg == DONE);
  assign bus.y    = y_reg;
  assign bus.eq   = eq_reg;
  assign bus.lt   = lt_reg;
  assign bus.gt   = gt_reg;
endmodule

// File: tb/tb_iter_compare_unit.sv
// Directed bench for iter_compare_unit (WIDTH=8, DIGIT=2): vector table
// plus hand-written back-to-back, ignored-start and mid-operation reset sequences.
module tb_iter_compare_unit;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_fail;

  iter_compare_unit_if #(.WIDTH(8)) bus ();

  iter_compare_unit #(.WIDTH(8), .DIGIT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] mode;
    logic       sgn;
    logic [7:0] y;
    logic       eq;
    logic       lt;
    logic       gt;
    int         lat;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one start pulse, then count cycles until done (bounded).
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic [1:0] m,
                        input logic s, output int lat, output bit busy_ok);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    bus.mode  = m;
    bus.sgn   = s;
    busy_ok   = 1'b1;
    step();
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 20) begin
      if (!bus.busy) busy_ok = 1'b0;
      step();
      lat++;
    end
    if (bus.busy) busy_ok = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic [7:0] y, input logic eq,
                            input logic lt, input logic gt);
    chk({tag, ".y"},  32'(bus.y),  32'(y));
    chk({tag, ".eq"}, 32'(bus.eq), 32'(eq));
    chk({tag, ".lt"}, 32'(bus.lt), 32'(lt));
    chk({tag, ".gt"}, 32'(bus.gt), 32'(gt));
  endtask

  initial begin
    int lat;
    bit busy_ok;
    bit saw_done;
    n_vec  = 0;
    n_fail = 0;

    //            a      b      mode   sgn   y      eq    lt    gt    lat
    vecs[0] = '{8'h01, 8'h00, 2'b00, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 5};
    vecs[1] = '{8'h80, 8'h7F, 2'b00, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 2};
    vecs[2] = '{8'h80, 8'h7F, 2'b00, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 2};
    vecs[3] = '{8'hF0, 8'h05, 2'b01, 1'b1, 8'h05, 1'b0, 1'b1, 1'b0, 2};
    vecs[4] = '{8'hF0, 8'h05, 2'b10, 1'b0, 8'h05, 1'b0, 1'b0, 1'b1, 2};
    vecs[5] = '{8'hA5, 8'hA5, 2'b00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5};
    vecs[6] = '{8'h3C, 8'h3D, 2'b11, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5};
    vecs[7] = '{8'h12, 8'h34, 2'b01, 1'b0, 8'h34, 1'b0, 1'b1, 1'b0, 3};
    vecs[8] = '{8'h7F, 8'hFF, 2'b10, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 2};
    vecs[9] = '{8'h5A, 8'h5A, 2'b10, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 5};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.mode  = '0;
    bus.sgn   = 1'b0;
    step();
    step();
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.done", 32'(bus.done), 32'd0);
    chk_result("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].sgn, lat, busy_ok);
      $display("vec %0d: a=%h b=%h mode=%0d sgn=%0d -> lat=%0d y=%h eq=%0d lt=%0d gt=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].sgn, lat, bus.y,
               bus.eq, bus.lt, bus.gt);
      chk($sformatf("vec%0d.lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d.busy", i), 32'(busy_ok), 32'd1);
      chk_result($sformatf("vec%0d", i), vecs[i].y, vecs[i].eq, vecs[i].lt, vecs[i].gt);
      step();
      chk($sformatf("vec%0d.done_pulse", i), 32'(bus.done), 32'd0);
    end

    // Back-to-back: CMP on equal operands, then MAX accepted during its DONE cycle.
    run_op(8'hA5, 8'hA5, 2'b00, 1'b0, lat, busy_ok);
    $display("b2b first: lat=%0d y=%h eq=%0d", lat, bus.y, bus.eq);
    chk("b2b1.lat", 32'(lat), 32'd5);
    chk_result("b2b1", 8'h00, 1'b1, 1'b0, 1'b0);
    run_op(8'hA5, 8'hA5, 2'b01, 1'b0, lat, busy_ok);
    $display("b2b second: lat=%0d y=%h eq=%0d", lat, bus.y, bus.eq);
    chk("b2b2.lat_total", 32'(5 + lat), 32'd10);
    chk("b2b2.busy", 32'(busy_ok), 32'd1);
    chk_result("b2b2", 8'hA5, 1'b1, 1'b0, 1'b0);
    step();

    // Outputs hold while a new operation runs; start in BUSY is ignored.
    bus.start = 1'b1;
    bus.a     = 8'h00;
    bus.b     = 8'h01;
    bus.mode  = 2'b00;
    bus.sgn   = 1'b0;
    step();                                   // t+1
    bus.start = 1'b0;
    chk("hold.y", 32'(bus.y), 32'h A5);
    chk("hold.eq", 32'(bus.eq), 32'd1);
    step();                                   // t+2
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    bus.b     = 8'h00;
    bus.mode  = 2'b01;
    step();                                   // t+3
    bus.start = 1'b0;
    lat = 3;
    while (!bus.done && lat < 20) begin
      step();
      lat++;
    end
    $display("ignored-start: lat=%0d y=%h lt=%0d", lat, bus.y, bus.lt);
    chk("ign.lat", 32'(lat), 32'd5);
    chk_result("ign", 8'h00, 1'b0, 1'b1, 1'b0);
    saw_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (bus.done) saw_done = 1'b1;
    end
    chk("ign.no_second_done", 32'(saw_done), 32'd0);

    // Reset in the middle of a 4-digit compare.
    bus.start = 1'b1;
    bus.a     = 8'h01;
    bus.b     = 8'h00;
    bus.mode  = 2'b00;
    bus.sgn   = 1'b0;
    step();                                   // t+1
    bus.start = 1'b0;
    step();                                   // t+2
    rst = 1'b1;
    step();                                   // t+3
    rst = 1'b0;
    $display("mid-reset: busy=%0d done=%0d y=%h eq=%0d lt=%0d gt=%0d",
             bus.busy, bus.done, bus.y, bus.eq, bus.lt, bus.gt);
    chk("mrst.busy", 32'(bus.busy), 32'd0);
    chk("mrst.done", 32'(bus.done), 32'd0);
    chk_result("mrst", 8'h00, 1'b0, 1'b0, 1'b0);
    saw_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    chk("mrst.quiet", 32'(saw_done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
